// File: rtl/sync_f2s_pkg.sv
// Shared types and default sizing for the fast-to-slow synchronizer scheduler.
package sync_f2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    GUARD
  } state_t;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_CNT_W   = 3;
  localparam int unsigned DEF_TO_CYC  = 64;
  localparam int unsigned DEF_GAP_CYC = 4;

endpackage

// File: rtl/sync_f2s_arb_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, else wrap to lowest.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  // Two passes: upper window [ptr, N_REQ) first, then the wrapped lower window.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!any && req[j] && (j >= 32'(ptr))) begin
        any = 1'b1;
        idx = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!any && req[j]) begin
        any = 1'b1;
        idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/sync_f2s_arb.sv
// Fast-domain scheduler sharing one fast-to-slow pulse synchronizer among N_REQ requesters.
module sync_f2s_arb
  import sync_f2s_pkg::*;
#(
  parameter  int unsigned N_REQ   = DEF_N_REQ,
  parameter  int unsigned CNT_W   = DEF_CNT_W,
  parameter  int unsigned TO_CYC  = DEF_TO_CYC,
  parameter  int unsigned GAP_CYC = DEF_GAP_CYC,
  localparam int unsigned ID_W    = $clog2(N_REQ)
) (
  input  logic             clk_f,
  input  logic             rstn_f,
  input  logic [N_REQ-1:0] req_i,
  input  logic             clr_i,
  input  logic             sync_ack_i,
  output logic             sync_req_o,
  output logic [ID_W-1:0]  sync_id_o,
  output logic [N_REQ-1:0] pend_o,
  output logic [N_REQ-1:0] done_o,
  output logic             busy_o,
  output logic [N_REQ-1:0] ovf_o,
  output logic             err_timeout_o
);

  localparam int unsigned      TMR_MAX  = (TO_CYC > GAP_CYC) ? TO_CYC : GAP_CYC;
  localparam int unsigned      TMR_W    = $clog2(TMR_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TO_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt [N_REQ];
  logic [ID_W-1:0]    ptr;
  logic [TMR_W-1:0]   tmr;
  logic               any;
  logic [ID_W-1:0]    gnt_idx;
  logic [N_REQ-1:0]   gnt_vec;
  logic               grant, ack_hit, to_hit;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req (pend_o),
    .ptr (ptr),
    .any (any),
    .idx (gnt_idx)
  );

  assign gnt_vec    = grant ? (N_REQ'(1) << gnt_idx) : '0;
  assign sync_req_o = (state == SEND);
  assign busy_o     = (state != IDLE);

  // Pending flags straight from the counters.
  always_comb begin
    pend_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pend_o[k] = |cnt[k];
    end
  end

  // State register.
  always_ff @(posedge clk_f or negedge rstn_f) begin
    if (!rstn_f) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state and per-cycle events; ack takes priority over timeout.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    ack_hit  = 1'b0;
    to_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          grant    = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (sync_ack_i) begin
          ack_hit  = 1'b1;
          state_nx = GUARD;
        end else if (tmr == TO_LAST) begin
          to_hit   = 1'b1;
          state_nx = GUARD;
        end
      end
      GUARD: begin
        if (tmr == GAP_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shared timer: restarts on launch and on entering GUARD, counts in WAIT_ACK/GUARD.
  always_ff @(posedge clk_f or negedge rstn_f) begin
    if (!rstn_f) begin
      tmr <= '0;
    end else if ((state == SEND) || ack_hit || to_hit) begin
      tmr <= '0;
    end else if ((state == WAIT_ACK) || (state == GUARD)) begin
      tmr <= tmr + 1'b1;
    end
  end

  // Latch the granted index and advance the round-robin pointer past it.
  always_ff @(posedge clk_f or negedge rstn_f) begin
    if (!rstn_f) begin
      sync_id_o <= '0;
      ptr       <= '0;
    end else if (grant) begin
      sync_id_o <= gnt_idx;
      ptr       <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // One-cycle completion pulse on the acked requester.
  always_ff @(posedge clk_f or negedge rstn_f) begin
    if (!rstn_f) done_o <= '0;
    else         done_o <= ack_hit ? (N_REQ'(1) << sync_id_o) : '0;
  end

  // Saturating pending counters; a request coinciding with its own grant nets to zero.
  always_ff @(posedge clk_f or negedge rstn_f) begin
    if (!rstn_f) begin
      cnt   <= '{default: '0};
      ovf_o <= '0;
    end else begin
      if (clr_i) ovf_o <= '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (req_i[k] && !gnt_vec[k]) begin
          if (cnt[k] == CNT_MAX) ovf_o[k] <= 1'b1;
          else                   cnt[k]   <= cnt[k] + 1'b1;
        end else if (!req_i[k] && gnt_vec[k]) begin
          cnt[k] <= cnt[k] - 1'b1;
        end
      end
    end
  end

  // Sticky timeout error; a same-cycle timeout beats the clear.
  always_ff @(posedge clk_f or negedge rstn_f) begin
    if (!rstn_f) begin
      err_timeout_o <= 1'b0;
    end else begin
      if (clr_i)  err_timeout_o <= 1'b0;
      if (to_hit) err_timeout_o <= 1'b1;
    end
  end

endmodule
